pad_bank_inout: RTL and testbench
=================================

// Module: pad_bank_inout
// PURPOSE
//  Parametrised bank of NUM_PADS bidirectional FPGA pads, one Xilinx IOBUF per channel (T = ~oe).
//  Adds per-channel input synchronisation, a programmable glitch filter, input inversion,
//  rise/fall event pulses and an optionally registered output/OE path.
//  Sits between the pad ring top-level and core logic in FPGA builds.
//  Each channel is controlled by its own pad_attributes_i slice.
// PARAMETERS
//  NUM_PADS     8   number of pad channels (>=1)
//  PADATTR      16  attribute bits per channel (>=3); bits [PADATTR-1:3] are ignored
//  SYNC_STAGES  2   input synchroniser flops (>=2)
//  FILT_CYCLES  4   stable cycles required by the glitch filter (>=1)
// PORTS
//  clk_i             in    1                  clock
//  rst_i             in    1                  synchronous reset, active-high
//  pad_in_i          in    NUM_PADS           core value driven onto each pad
//  pad_oe_i          in    NUM_PADS           per-pad output enable, 1 = drive
//  pad_out_o         out   NUM_PADS           filtered, optionally inverted pad value to core
//  pad_rise_o        out   NUM_PADS           1-cycle pulse on 0->1 of pad_out_o
//  pad_fall_o        out   NUM_PADS           1-cycle pulse on 1->0 of pad_out_o
//  pad_io            inout NUM_PADS           physical pads
//  pad_attributes_i  in    NUM_PADS*PADATTR   channel n = [n*PADATTR +: PADATTR];
//                                             bit0 filt_en, bit1 out_reg_en, bit2 in_inv
// BEHAVIOUR
//  Reset (rst_i=1 at a clk_i edge), all channels:
//   - all sync/filter/counter/edge/output flops = 0
//   - pad_out_o = 0, pad_rise_o = 0, pad_fall_o = 0
//   - registered oe_q = 0, so pads in out_reg_en mode are tri-stated
//  Output path, per channel:
//   - out_reg_en=0: IOBUF I = pad_in_i, T = ~pad_oe_i (combinational)
//   - out_reg_en=1: I = in_q, T = ~oe_q; both captured from pad_in_i/pad_oe_i every cycle (1-cycle delay)
//   - in_q/oe_q are always loaded, so switching out_reg_en never drives stale data
//  Input path, per channel:
//   - raw = IOBUF O ^ in_inv
//   - raw passes a SYNC_STAGES flop chain; sync = last stage
//   - filt_q register feeds pad_out_o = filt_q
//  Filter disabled (filt_en=0):
//   - filt_q <= sync every cycle; cnt held at 0
//   - latency pad->pad_out_o = SYNC_STAGES+1 cycles
//  Filter enabled (filt_en=1):
//   - sync == filt_q: cnt <= 0
//   - sync != filt_q and cnt < FILT_CYCLES-1: cnt <= cnt+1
//   - sync != filt_q and cnt == FILT_CYCLES-1: filt_q <= sync, cnt <= 0
//   - result: a change must hold FILT_CYCLES consecutive cycles at sync; latency = SYNC_STAGES+FILT_CYCLES
//   - a shorter pulse is dropped and the counter restarts from 0
//   - cnt width = $clog2(FILT_CYCLES+1); FILT_CYCLES=1 gives the same timing as filter disabled
//  Filter enable changes:
//   - clearing filt_en mid-count: cnt <= 0, filt_q resumes direct tracking next cycle
//   - setting filt_en: counting starts from cnt=0
//  Edges:
//   - prev_q <= filt_q each cycle
//   - rise = filt_q & ~prev_q; fall = ~filt_q & prev_q
//   - each pulse lasts exactly 1 cycle, coincident with the pad_out_o change
//  Inversion and loopback:
//   - toggling in_inv flips raw, so it propagates like a real pad change (subject to filter) and yields an edge
//   - a driven pad (oe=1) reads back its own driven value through the input path (loopback)
//  Channels are fully independent: no shared state, any mix of attributes.
//  Reset mid-filter or mid-sync: everything returns to reset values on that edge and
//  no edge pulse follows reset release.
// TESTING
//  1 Reset with pad_oe_i=FF, out_reg_en=1 all channels -> pads Z during reset and the first cycle after;
//    pad_out_o=00; no rise/fall.
//  2 filt_en=0, external pad0 0->1 at cycle 10 -> pad_out_o[0]=1 at cycle 13 (SYNC_STAGES=2);
//    pad_rise_o[0] high for cycle 13 only.
//  3 filt_en=1, FILT_CYCLES=4: 3-cycle high glitch on pad1 -> pad_out_o[1] stays 0, no pulse;
//    a 4-cycle high -> pad_out_o[1]=1 six cycles after the edge.
//  4 out_reg_en=1, pad_in_i[2]=1, pad_oe_i[2]=1 at cycle 20 -> pad2 driven 1 from cycle 21;
//    pad_out_o[2]=1 via loopback at cycle 24 (filter off).
//  5 in_inv toggled on pad3 while pad held 0 -> pad_out_o[3]=1 after sync latency; one pad_rise_o[3] pulse.
//  6 rst_i asserted for 1 cycle while pad4 filter cnt=2 -> cnt and pad_out_o[4] return to 0;
//    other channels with distinct attributes behave independently after release.

Source files
------------

// File: rtl/pad_bank_inout.sv
// Bank of bidirectional pads: per-channel tristate driver with an optional registered I/OE path,
// input synchroniser, programmable glitch filter, input inversion and rise/fall event pulses.
module pad_bank_inout #(
  parameter int NUM_PADS    = 8,
  parameter int PADATTR     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PADS-1:0]           pad_in_i,
  input  logic [NUM_PADS-1:0]           pad_oe_i,
  output logic [NUM_PADS-1:0]           pad_out_o,
  output logic [NUM_PADS-1:0]           pad_rise_o,
  output logic [NUM_PADS-1:0]           pad_fall_o,
  inout  wire  [NUM_PADS-1:0]           pad_io,
  input  logic [NUM_PADS*PADATTR-1:0]   pad_attributes_i
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  for (genvar n = 0; n < NUM_PADS; n++) begin : g_ch
    logic                   filt_en;
    logic                   out_reg_en;
    logic                   in_inv;
    logic                   pad_drv;
    logic                   pad_t;
    logic                   pad_rd;
    logic                   raw;
    logic                   sync;
    logic                   in_q, in_d;
    logic                   oe_q, oe_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign filt_en    = pad_attributes_i[n*PADATTR + 0];
    assign out_reg_en = pad_attributes_i[n*PADATTR + 1];
    assign in_inv     = pad_attributes_i[n*PADATTR + 2];

    if (PADATTR > 3) begin : g_unused
      logic unused_attr;
      assign unused_attr = ^pad_attributes_i[n*PADATTR + 3 +: PADATTR - 3];
    end

    // IOBUF equivalent (T = ~oe); synthesis maps this top-level tristate onto the pad IOBUF.
    assign pad_drv   = out_reg_en ? in_q : pad_in_i[n];
    assign pad_t     = out_reg_en ? ~oe_q : ~pad_oe_i[n];
    assign pad_io[n] = pad_t ? 1'bz : pad_drv;
    assign pad_rd    = pad_io[n];

    assign raw  = pad_rd ^ in_inv;
    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
      in_d   = pad_in_i[n];
      oe_d   = pad_oe_i[n];
      sync_d = {sync_q[SYNC_STAGES-2:0], raw};
      prev_d = filt_q;
      filt_d = filt_q;
      cnt_d  = '0;
      if (!filt_en) begin
        filt_d = sync;
      end else if (sync != filt_q) begin
        // A change is accepted only after FILT_CYCLES consecutive differing samples.
        if (cnt_q == CNT_MAX) begin
          filt_d = sync;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        in_q   <= 1'b0;
        oe_q   <= 1'b0;
        sync_q <= '0;
        filt_q <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        in_q   <= in_d;
        oe_q   <= oe_d;
        sync_q <= sync_d;
        filt_q <= filt_d;
        prev_q <= prev_d;
        cnt_q  <= cnt_d;
      end
    end

    assign pad_out_o[n]  = filt_q;
    assign pad_rise_o[n] = filt_q & ~prev_q;
    assign pad_fall_o[n] = ~filt_q & prev_q;
  end

endmodule

// File: tb/tb_pad_bank_inout.sv
// Bench for pad_bank_inout: directed scenarios plus randomized traffic, all outputs checked every
// cycle against a sample-history reference model through an expected-value queue.
module tb_pad_bank_inout;

  localparam int NP = 8;
  localparam int PA = 16;
  localparam int SS = 2;
  localparam int FC = 4;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     pad_in;
  logic [NP-1:0]     pad_oe;
  logic [NP*PA-1:0]  attr;
  logic [NP-1:0]     ext_en;
  logic [NP-1:0]     ext_val;
  logic [NP-1:0]     pad_out;
  logic [NP-1:0]     pad_rise;
  logic [NP-1:0]     pad_fall;
  wire  [NP-1:0]     pad_io;

  logic [3*NP-1:0]   exp_q[$];
  logic [NP-1:0]     raw_hist[$];
  int                n_checks = 0;
  int                n_pass = 0;

  // Off-chip drivers, one per pad.
  for (genvar g = 0; g < NP; g++) begin : g_ext
    assign pad_io[g] = ext_en[g] ? ext_val[g] : 1'bz;
  end

  pad_bank_inout #(
    .NUM_PADS(NP), .PADATTR(PA), .SYNC_STAGES(SS), .FILT_CYCLES(FC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pad_in_i(pad_in),
    .pad_oe_i(pad_oe),
    .pad_out_o(pad_out),
    .pad_rise_o(pad_rise),
    .pad_fall_o(pad_fall),
    .pad_io(pad_io),
    .pad_attributes_i(attr)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: what each pad carries, the raw sample stream delayed by SS samples,
  // and a run length of consecutive samples disagreeing with the accepted value.
  initial begin : model
    logic [NP-1:0] m_out, m_in_q, m_oe_q, raw, sync, nout, rise, fall;
    int            m_run[NP];
    logic          oreg, drv, val, pv;
    m_out = '0; m_in_q = '0; m_oe_q = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_out = '0; m_in_q = '0; m_oe_q = '0;
        for (int c = 0; c < NP; c++) m_run[c] = 0;
        raw_hist.delete();
        repeat (SS) raw_hist.push_back('0);
        exp_q.push_back('0);
      end else begin
        for (int c = 0; c < NP; c++) begin
          oreg = attr[c*PA + 1];
          drv  = oreg ? m_oe_q[c] : pad_oe[c];
          val  = oreg ? m_in_q[c] : pad_in[c];
          pv   = drv ? val : (ext_en[c] & ext_val[c]);
          raw[c] = pv ^ attr[c*PA + 2];
        end
        raw_hist.push_back(raw);
        sync = raw_hist.pop_front();
        nout = m_out;
        for (int c = 0; c < NP; c++) begin
          if (!attr[c*PA + 0]) begin
            nout[c] = sync[c];
            m_run[c] = 0;
          end else if (sync[c] == m_out[c]) begin
            m_run[c] = 0;
          end else begin
            m_run[c] = m_run[c] + 1;
            if (m_run[c] == FC) begin
              nout[c] = sync[c];
              m_run[c] = 0;
            end
          end
        end
        rise = nout & ~m_out;
        fall = ~nout & m_out;
        m_out = nout;
        m_in_q = pad_in;
        m_oe_q = pad_oe;
        exp_q.push_back({nout, rise, fall});
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    logic [3*NP-1:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pad_out, pad_rise, pad_fall};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL outputs @%0t: got out/rise/fall=%h/%h/%h expected %h/%h/%h", $time,
                      a[3*NP-1:2*NP], a[2*NP-1:NP], a[NP-1:0], e[3*NP-1:2*NP], e[2*NP-1:NP], e[NP-1:0]);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_attr(input int ch, input logic f, input logic o, input logic i);
    attr[ch*PA +: 3] = {i, o, f};
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_out(input int ch, input logic val, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (pad_out[ch] == val) begin
        cyc = i;
        break;
      end
    end
  endtask

  function automatic int driven_ones();
    int k = 0;
    for (int c = 0; c < NP; c++) if (pad_io[c] === 1'b1) k++;
    return k;
  endfunction

  // Stimulus
  initial begin : stim
    int   cyc;
    logic seen;
    rst = 1'b1;
    pad_in = '1;
    pad_oe = '1;
    ext_en = '0;
    ext_val = '0;
    attr = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < NP; c++) set_attr(c, 1'b0, 1'b1, 1'b0);

    // Reset with registered OE requested everywhere: pads stay undriven
    tick(3);
    check("rst_pads_undriven", driven_ones(), 0);
    check("rst_pad_out", int'(pad_out), 0);
    rst = 1'b0;
    check("first_cycle_pads_undriven", driven_ones(), 0);
    tick(1);
    check("pads_driven_after_reset", driven_ones(), NP);
    pad_oe = '0;
    pad_in = '0;
    tick(2);
    for (int c = 0; c < NP; c++) set_attr(c, 1'b0, 1'b0, 1'b0);
    ext_en = '1;
    tick(8);

    // Unfiltered edge on pad0
    ext_val[0] = 1'b1;
    wait_out(0, 1'b1, 20, cyc);
    check("t2_latency", cyc, SS + 1);
    check("t2_rise", int'(pad_rise[0]), 1);
    tick(1);
    check("t2_rise_one_cycle", int'(pad_rise[0]), 0);

    // Glitch filter on pad1
    set_attr(1, 1'b1, 1'b0, 1'b0);
    tick(2);
    ext_val[1] = 1'b1;
    tick(FC - 1);
    ext_val[1] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      seen = seen | pad_out[1] | pad_rise[1];
    end
    check("t3_glitch_dropped", int'(seen), 0);
    ext_val[1] = 1'b1;
    wait_out(1, 1'b1, 20, cyc);
    check("t3_filtered_latency", cyc, SS + FC);

    // Registered output path with loopback on pad2
    set_attr(2, 1'b0, 1'b1, 1'b0);
    ext_en[2] = 1'b0;
    tick(2);
    pad_in[2] = 1'b1;
    pad_oe[2] = 1'b1;
    #1;
    check("t4_oe_delayed", int'(pad_io[2] === 1'b1), 0);
    wait_out(2, 1'b1, 20, cyc);
    check("t4_loopback_latency", cyc, SS + 2);
    check("t4_pad_driven", int'(pad_io[2] === 1'b1), 1);

    // Inversion on pad3 while the pad holds 0
    set_attr(3, 1'b0, 1'b0, 1'b1);
    wait_out(3, 1'b1, 20, cyc);
    check("t5_inv_latency", cyc, SS + 1);
    check("t5_rise", int'(pad_rise[3]), 1);
    tick(1);
    check("t5_rise_one_cycle", int'(pad_rise[3]), 0);

    // Reset in the middle of a filter count on pad4
    set_attr(4, 1'b1, 1'b0, 1'b0);
    set_attr(5, 1'b0, 1'b0, 1'b1);
    set_attr(6, 1'b1, 1'b1, 1'b1);
    tick(2);
    ext_val[4] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_reset_out", int'(pad_out), 0);
    check("t6_no_pulse", int'({pad_rise, pad_fall}), 0);
    wait_out(4, 1'b1, 20, cyc);
    check("t6_refilter_latency", cyc, SS + FC);
    check("t6_ch5_independent", int'(pad_out[5]), 1);
    check("t6_ch2_loopback", int'(pad_out[2]), 1);

    // Randomized traffic: pads 2, 6, 7 loop back, the rest are driven off-chip
    ext_en[6] = 1'b0;
    ext_en[7] = 1'b0;
    tick(1);
    pad_oe[6] = 1'b1;
    pad_oe[7] = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (k % 25 == 0)
        for (int c = 0; c < NP; c++) attr[c*PA +: PA] = PA'($urandom);
      for (int c = 0; c < NP; c++) begin
        if (c == 2 || c == 6 || c == 7) begin
          if ($urandom_range(0, 5) == 0) pad_in[c] = ~pad_in[c];
        end else begin
          if ($urandom_range(0, 5) == 0) ext_val[c] = ~ext_val[c];
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(8);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
